// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter. Round-robin between the
// ALU (req0) and load/multi-cycle (req1) ports, one registered output stage,
// x0 writes swallowed without touching the stage or the RR pointer, and a
// combinational bypass lookup on the staged write.
module regfile_wb_arbiter #(
  parameter int          XLEN          = 32,
  parameter logic [4:0]  ZERO_REG_ADDR = 5'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_wdata,
  input  logic [4:0]      qry_addr,
  output logic            qry_hit,
  output logic [XLEN-1:0] qry_data,
  output logic            last_grant
);

  logic nz0, nz1, gnt0, gnt1;

  // Arbitration: only non-x0 writes compete; ties go to the requester
  // that was not granted last.
  always_comb begin
    nz0  = req0_valid && (req0_rd != ZERO_REG_ADDR);
    nz1  = req1_valid && (req1_rd != ZERO_REG_ADDR);
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = nz0 && (!nz1 || last_grant);
      gnt1 = nz1 && (!nz0 || !last_grant);
    end
  end

  // Ready: x0 writes are dropped immediately, others need the grant.
  // Nothing is accepted while reset is held.
  always_comb begin
    req0_ready = !rst && req0_valid && ((req0_rd == ZERO_REG_ADDR) || gnt0);
    req1_ready = !rst && req1_valid && ((req1_rd == ZERO_REG_ADDR) || gnt1);
  end

  // Output stage and RR pointer: reloaded every cycle so each accepted
  // write is visible for exactly one cycle; idle cycles present zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we       <= 1'b0;
      rf_rd_addr  <= '0;
      rf_rd_wdata <= '0;
      last_grant  <= 1'b1;
    end else begin
      rf_we       <= gnt0 || gnt1;
      rf_rd_addr  <= gnt0 ? req0_rd   : (gnt1 ? req1_rd   : '0);
      rf_rd_wdata <= gnt0 ? req0_data : (gnt1 ? req1_data : '0);
      if (gnt0)      last_grant <= 1'b0;
      else if (gnt1) last_grant <= 1'b1;
    end
  end

  // Bypass lookup against the staged write; never hits on x0.
  always_comb begin
    qry_hit  = rf_we && (qry_addr == rf_rd_addr) && (qry_addr != ZERO_REG_ADDR);
    qry_data = qry_hit ? rf_rd_wdata : '0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1ns after a rising
// edge, combinational outputs are checked 1ns later, registered outputs 1ns
// after the next rising edge.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [4:0]      req0_rd, req1_rd;
  logic [XLEN-1:0] req0_data, req1_data;
  logic            rf_we;
  logic [4:0]      rf_rd_addr;
  logic [XLEN-1:0] rf_rd_wdata;
  logic [4:0]      qry_addr;
  logic            qry_hit;
  logic [XLEN-1:0] qry_data;
  logic            last_grant;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .ZERO_REG_ADDR(5'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_wdata(rf_rd_wdata),
    .qry_addr(qry_addr), .qry_hit(qry_hit), .qry_data(qry_data),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; qry_addr = 0;
    req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h1;
    req1_valid = 1; req1_rd = 5'd4; req1_data = 32'h2;
    tick();
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== '0) begin errors++; $display("FAIL reset_out got we=%b a=%0d d=%h exp 0", rf_we, rf_rd_addr, rf_rd_wdata); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_lg got %b exp 1", last_grant); end
    qry_addr = 5'd0;
    #1;
    checks++; if ({qry_hit, qry_data} !== '0) begin errors++; $display("FAIL reset_qry got %b %h exp 0", qry_hit, qry_data); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_hold_we got %b exp 0", rf_we); end
    rst = 0;
    idle_inputs();
    #1;
  endtask

  task automatic test_single();
    req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL single_out got we=%b a=%0d d=%h exp 1 5 deadbeef", rf_we, rf_rd_addr, rf_rd_wdata); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL single_lg got %b exp 0", last_grant); end
    tick();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== '0) begin errors++; $display("FAIL single_drain got we=%b a=%0d d=%h exp 0", rf_we, rf_rd_addr, rf_rd_wdata); end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 5'd4; req1_data = 32'h22;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_ready1 got %b exp 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 0;
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL cont_w1 got we=%b a=%0d d=%h exp 1 3 11", rf_we, rf_rd_addr, rf_rd_wdata); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL cont_lg1 got %b exp 0", last_grant); end
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL cont_ready2 got %b exp 1", req1_ready); end
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd4, 32'h22}) begin errors++; $display("FAIL cont_w2 got we=%b a=%0d d=%h exp 1 4 22", rf_we, rf_rd_addr, rf_rd_wdata); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL cont_lg2 got %b exp 1", last_grant); end
  endtask

  task automatic test_x0_filter();
    // last_grant is 1 here
    req0_valid = 1; req0_rd = 5'd7; req0_data = 32'h1;
    req1_valid = 1; req1_rd = 5'd0; req1_data = 32'hFFFF;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b11) begin errors++; $display("FAIL x0_ready got %b exp 11", {req0_ready, req1_ready}); end
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd7, 32'h1}) begin errors++; $display("FAIL x0_w got we=%b a=%0d d=%h exp 1 7 1", rf_we, rf_rd_addr, rf_rd_wdata); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL x0_lg got %b exp 0", last_grant); end
    // lone x0 write: accepted, nothing staged, pointer unchanged
    req0_valid = 1; req0_rd = 5'd0; req0_data = 32'hABCD;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL x0_lone_ready got %b exp 1", req0_ready); end
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== '0) begin errors++; $display("FAIL x0_lone_out got we=%b a=%0d d=%h exp 0", rf_we, rf_rd_addr, rf_rd_wdata); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL x0_lone_lg got %b exp 0", last_grant); end
  endtask

  task automatic test_same_rd();
    // last_grant is 0 -> req1 first
    req0_valid = 1; req0_rd = 5'd9; req0_data = 32'hA;
    req1_valid = 1; req1_rd = 5'd9; req1_data = 32'hB;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL same_ready got %b exp 01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 0;
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd9, 32'hB}) begin errors++; $display("FAIL same_w1 got we=%b a=%0d d=%h exp 1 9 b", rf_we, rf_rd_addr, rf_rd_wdata); end
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd9, 32'hA}) begin errors++; $display("FAIL same_w2 got we=%b a=%0d d=%h exp 1 9 a", rf_we, rf_rd_addr, rf_rd_wdata); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL same_lg got %b exp 0", last_grant); end
  endtask

  task automatic test_bypass();
    req0_valid = 1; req0_rd = 5'd12; req0_data = 32'h55;
    tick();
    idle_inputs();
    qry_addr = 5'd12;
    #1;
    checks++; if ({qry_hit, qry_data} !== {1'b1, 32'h55}) begin errors++; $display("FAIL byp_hit got %b %h exp 1 55", qry_hit, qry_data); end
    qry_addr = 5'd0;
    #1;
    checks++; if ({qry_hit, qry_data} !== '0) begin errors++; $display("FAIL byp_x0 got %b %h exp 0 0", qry_hit, qry_data); end
    qry_addr = 5'd13;
    #1;
    checks++; if ({qry_hit, qry_data} !== '0) begin errors++; $display("FAIL byp_miss got %b %h exp 0 0", qry_hit, qry_data); end
    qry_addr = 5'd12;
    tick();
    checks++; if ({qry_hit, qry_data} !== '0) begin errors++; $display("FAIL byp_drained got %b %h exp 0 0", qry_hit, qry_data); end
    qry_addr = 5'd0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_addr [4];
    exp_addr[0] = 5'd2; exp_addr[1] = 5'd1; exp_addr[2] = 5'd2; exp_addr[3] = 5'd1;
    // last_grant is 0 -> req1 (x2) first, then strict alternation
    req0_valid = 1; req0_rd = 5'd1; req0_data = 32'h100;
    req1_valid = 1; req1_rd = 5'd2; req1_data = 32'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({rf_we, rf_rd_addr} !== {1'b1, exp_addr[i]}) begin errors++; $display("FAIL b2b_%0d got we=%b a=%0d exp 1 %0d", i, rf_we, rf_rd_addr, exp_addr[i]); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midop();
    req0_valid = 1; req0_rd = 5'd6; req0_data = 32'h77;
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd6, 32'h77}) begin errors++; $display("FAIL mid_stage got we=%b a=%0d d=%h exp 1 6 77", rf_we, rf_rd_addr, rf_rd_wdata); end
    req1_valid = 1; req1_rd = 5'd8; req1_data = 32'h88;
    rst = 1;
    qry_addr = 5'd6;
    #1;
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata, qry_hit, qry_data} !== '0) begin errors++; $display("FAIL mid_clear got we=%b a=%0d d=%h h=%b q=%h exp 0", rf_we, rf_rd_addr, rf_rd_wdata, qry_hit, qry_data); end
    checks++; if ({last_grant, req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_lg_ready got %b exp 10", {last_grant, req1_ready}); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_no_we got %b exp 0", rf_we); end
    rst = 0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL mid_resume_ready got %b exp 1", req1_ready); end
    tick();
    idle_inputs();
    checks++; if ({rf_we, rf_rd_addr, rf_rd_wdata} !== {1'b1, 5'd8, 32'h88}) begin errors++; $display("FAIL mid_resume got we=%b a=%0d d=%h exp 1 8 88", rf_we, rf_rd_addr, rf_rd_wdata); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_x0_filter();
    test_same_rd();
    test_bypass();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
